// File: rtl/bcd_pkg.sv
// Shared BCD digit types, constants and load sanitizing helper.
// Used by bcd_down_digit and bcd_down_count.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // Clamp any non-BCD nibble to 9.
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-count digit with parallel load and ripple borrow.
// Ports: clk, rst_n, load, load_digit, bin -> q, bout (bin & q==0).
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= bcd_sanitize(load_digit);
        end else if (bin) begin
            q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        end
    end

    assign bout = bin & (q == 4'd0);

endmodule

// File: rtl/bcd_down_count.sv
// Multi-digit packed-BCD down counter: load > en > hold, zero flag,
// one-cycle borrow pulse on decrement at all-zero.
// Ports: clk, rst_n, load, load_val, en -> qout, zero, borrow.
// Macro BCD_DOWN_WRAP_EN: wrap 0 -> all nines; default saturates at 0.
module bcd_down_count
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                en,
    output logic [4*DIGITS-1:0] qout,
    output logic                zero,
    output logic                borrow
);

    localparam logic [4*DIGITS-1:0] ONE = (4*DIGITS)'(1);

    logic [DIGITS:0]     chain;
    logic [4*DIGITS-1:0] load_san;
    logic                all_zero;
    logic                dec;
    logic                zero_d;
    logic                borrow_d;

    assign all_zero = (qout == '0);
    assign dec      = en & ~load;

`ifdef BCD_DOWN_WRAP_EN
    assign chain[0] = dec;
`else
    // Block the ripple at all-zero so the count saturates.
    assign chain[0] = dec & ~all_zero;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign load_san[4*g +: 4] = bcd_sanitize(load_val[4*g +: 4]);

        bcd_down_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load),
            .load_digit (load_val[4*g +: 4]),
            .bin        (chain[g]),
            .q          (qout[4*g +: 4]),
            .bout       (chain[g+1])
        );
    end

    always_comb begin
        zero_d = zero;
        if (load) begin
            zero_d = (load_san == '0);
        end else if (dec) begin
`ifdef BCD_DOWN_WRAP_EN
            zero_d = (qout == ONE);
`else
            zero_d = all_zero | (qout == ONE);
`endif
        end
    end

    // Ripple-out flags a wrap; the explicit term covers the gated
    // saturating case where the chain is never entered.
    assign borrow_d = chain[DIGITS] | (dec & all_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero   <= 1'b1;
            borrow <= 1'b0;
        end else begin
            zero   <= zero_d;
            borrow <= borrow_d;
        end
    end

endmodule
